dfe_feedback_canceller: RTL and testbench
=========================================

Name: dfe_feedback_canceller

Overview:
- Rx-side DFE summing stage. Sits directly upstream of the slicer/decision stage and drives its `estimation`/`e_valid` inputs.
- Accepts one equalised Rx sample at a time, subtracts post-cursor ISI and forwards the result to the slicer.
- ISI is the tap-weighted sum of past PAM4 decisions. The slicer returns its decision (`feedback_value`/`f_valid`), which is shifted into a decision history for the next symbol.
- Loop is serialised: one symbol is in flight at a time.

Parameters:
- PULSE_RESPONSE_LENGTH, 2, main cursor plus post-cursors; NT = PULSE_RESPONSE_LENGTH-1 feedback taps, must be >=2 total.
- SIGNAL_RESOLUTION, 8, tap coefficient width (signed); data width W = SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH.
- TAP_FRAC_BITS, 6, fractional bits of tap coefficients (Q format).
- FB_LATENCY, 1, cycles after the e_valid cycle until the slicer's feedback is valid; range 1..7.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- s_data  in  W  signed Rx sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- tap_coeff  in  NT*SIGNAL_RESOLUTION  signed taps; tap k (k=1..NT) at bits [k*SR-1 -: SR].
- hist_clr  in  1  synchronous clear of the decision history.
- estimation  out  W  signed ISI-cancelled sample, to the slicer.
- e_valid  out  1  one-cycle strobe for estimation.
- feedback_value  in  W  signed slicer decision.
- f_valid  in  1  slicer decision valid (level).
- d_out  out  W  decision committed to history.
- d_valid  out  1  one-cycle strobe for d_out.
- erasure_cnt  out  16  count of captures with f_valid=0, saturating at 0xFFFF.

Behaviour:
- Reset (rstn low, async): state=IDLE; s_ready=1; estimation=0; e_valid=0; d_out=0; d_valid=0; erasure_cnt=0; history=0; any in-flight sample is discarded.
- State machine:
  - IDLE: s_ready=1. On s_valid at an edge, latch s_data into sample_q and go to CALC. Upstream holds s_data stable while s_valid & !s_ready.
  - CALC: s_ready=0. At the edge, register estimation, set e_valid=1, cnt=0, go to WAIT.
  - WAIT: e_valid is high only in the first WAIT cycle and clears at the next edge. cnt increments each edge. In the cycle where cnt==FB_LATENCY, sample f_valid/feedback_value at the closing edge (capture), then go to IDLE.
- Capture:
  - Shift history: h[NT]..h[2] take h[NT-1]..h[1]; h[1] takes the new decision.
  - New decision = feedback_value if f_valid, else 0, and erasure_cnt increments.
  - d_out = new decision, d_valid=1 for one cycle.
- Timing with FB_LATENCY=1:
  - Accept at edge E0; estimation/e_valid are registered at E1; capture at E3.
  - One symbol per FB_LATENCY+3 cycles.
- Arithmetic:
  - isi = sum over k of h[k]*tap_k. Products are W+SR bits signed; the sum is held without overflow (W+SR+clog2(NT)+1 bits).
  - isi is then arithmetic-shifted right by TAP_FRAC_BITS, i.e. floor toward -inf.
  - diff = sample_q - isi, computed in full width, then reduced to W bits (see Optional Feature).
  - tap_coeff is sampled only in CALC. Changing it at other times has no effect on the in-flight symbol.
- hist_clr: clears all h[k] at the edge, in any state. When coincident with a capture, the clear wins (history=0), but d_out/d_valid/erasure_cnt still update.
- Simultaneous events: rstn overrides everything. s_valid outside IDLE is not accepted.

Optional Feature:
- Macro DFE_SATURATE_EN.
- Defined: diff saturates to [-2^(W-1), 2^(W-1)-1].
- Not defined: diff is truncated to its low W bits (two's-complement wrap).
- Either way the rest of the behaviour is unchanged.

Test Plan:
- Defaults throughout (W=16, SR=8, FRAC=6, NT=1).
1. Reset: hold rstn low, then release -> s_ready=1, e_valid=0, estimation=0, d_valid=0, erasure_cnt=0.
2. History 0, tap1=32:
   - Drive sample 100 -> estimation=100 with a one-cycle e_valid exactly 2 edges after accept.
   - Return feedback 84, f_valid=1 -> d_out=84 with a d_valid pulse.
   - Next sample 60 -> isi=84*32>>>6=42 -> estimation=18.
3. Negative and floor:
   - History -84, tap1=32, sample -50 -> estimation=-8.
   - History -28, tap1=1, sample 0 -> isi=-1, estimation=1.
4. Erasure: f_valid=0 at capture -> d_out=0, d_valid pulse, erasure_cnt=1. Next sample 40 -> estimation=40.
5. Saturation: history -84, tap1=127, sample 32767 -> isi=-167.
   - With DFE_SATURATE_EN -> estimation=32767.
   - Without DFE_SATURATE_EN -> estimation=-32602.
6. Async reset mid-WAIT while e_valid=1:
   - e_valid and history are cleared immediately, without waiting for a clock edge.
   - After release, s_ready=1.
   - Next sample 100 -> estimation=100.
   - hist_clr pulsed at a capture edge -> next estimation equals the raw sample.

Source files
------------

// File: rtl/dfe_feedback_canceller.sv
`default_nettype none
// ============================================================================
// Module      : dfe_feedback_canceller
// Description : Rx-side DFE summing stage. Takes one equalised sample at a
//               time, subtracts post-cursor ISI (tap-weighted sum of past
//               PAM4 decisions), hands the result to the slicer, then waits
//               for the slicer's decision and shifts it into the history.
//               Only one symbol is in flight at a time.
// Ports       : clk, rstn (async, active-low)
//               s_data/s_valid/s_ready      : sample input handshake
//               tap_coeff                   : signed taps, tap k at [k*SR-1 -: SR]
//               hist_clr                    : synchronous history clear
//               estimation/e_valid          : ISI-cancelled sample to slicer
//               feedback_value/f_valid      : slicer decision (level valid)
//               d_out/d_valid               : decision committed to history
//               erasure_cnt                 : saturating count of f_valid=0 captures
// Options     : DFE_SATURATE_EN - saturate the difference to W bits instead
//               of two's-complement wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module dfe_feedback_canceller #(
  parameter int PULSE_RESPONSE_LENGTH = 2,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int TAP_FRAC_BITS         = 6,
  parameter int FB_LATENCY            = 1
) (
  input  logic                                                        clk,
  input  logic                                                        rstn,
  input  logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0]   s_data,
  input  logic                                                        s_valid,
  output logic                                                        s_ready,
  input  logic [(PULSE_RESPONSE_LENGTH-1)*SIGNAL_RESOLUTION-1:0]      tap_coeff,
  input  logic                                                        hist_clr,
  output logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0]   estimation,
  output logic                                                        e_valid,
  input  logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0]   feedback_value,
  input  logic                                                        f_valid,
  output logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0]   d_out,
  output logic                                                        d_valid,
  output logic [15:0]                                                 erasure_cnt
);

  localparam int c_nt = PULSE_RESPONSE_LENGTH - 1;
  localparam int c_sr = SIGNAL_RESOLUTION;
  localparam int c_w  = SIGNAL_RESOLUTION * PULSE_RESPONSE_LENGTH;
  localparam int c_pw = c_w + c_sr;                 // one product
  localparam int c_sw = c_pw + $clog2(c_nt) + 1;    // sum of all products, no overflow
  localparam int c_dw = c_sw + 1;                   // sample - isi, full width

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_calc = 2'd1;
  localparam logic [1:0] c_wait = 2'd2;

  localparam logic [2:0] c_fb_lat = 3'(FB_LATENCY);

  logic [1:0]             r_state;
  logic [2:0]             r_cnt;
  logic signed [c_w-1:0]  r_sample;
  logic signed [c_w-1:0]  r_hist [1:c_nt];
  logic signed [c_w-1:0]  r_est;
  logic                   r_ev;
  logic signed [c_w-1:0]  r_dout;
  logic                   r_dv;
  logic [15:0]            r_ecnt;

  logic signed [c_pw-1:0] w_prod [1:c_nt];
  logic signed [c_sw-1:0] w_sum;
  logic signed [c_sw-1:0] w_isi;
  logic signed [c_dw-1:0] w_diff;
  logic signed [c_w-1:0]  w_est;
  logic signed [c_w-1:0]  w_decision;
  logic                   w_capture;

  // Both operands are sign-extended to the product width so the multiply is
  // done at full precision; a W x SR signed product always fits in W+SR bits.
  for (genvar k = 1; k <= c_nt; k++) begin : g_tap
    logic signed [c_pw-1:0] w_h_ext;
    logic signed [c_pw-1:0] w_t_ext;
    assign w_h_ext  = {{c_sr{r_hist[k][c_w-1]}}, r_hist[k]};
    assign w_t_ext  = {{c_w{tap_coeff[k*c_sr-1]}}, tap_coeff[k*c_sr-1 -: c_sr]};
    assign w_prod[k] = w_h_ext * w_t_ext;
  end

  always_comb begin
    w_sum = '0;
    for (int k = 1; k <= c_nt; k++) begin
      w_sum = w_sum + {{(c_sw-c_pw){w_prod[k][c_pw-1]}}, w_prod[k]};
    end
  end

  // Arithmetic shift drops the Q fraction, rounding toward -inf.
  assign w_isi  = w_sum >>> TAP_FRAC_BITS;
  assign w_diff = {{(c_dw-c_w){r_sample[c_w-1]}}, r_sample} - {w_isi[c_sw-1], w_isi};

`ifdef DFE_SATURATE_EN
  // In range when every bit from the W-bit sign position upward agrees.
  always_comb begin
    if ((w_diff[c_dw-1:c_w-1] == '0) || (w_diff[c_dw-1:c_w-1] == '1)) begin
      w_est = w_diff[c_w-1:0];
    end else if (w_diff[c_dw-1]) begin
      w_est = {1'b1, {(c_w-1){1'b0}}};
    end else begin
      w_est = {1'b0, {(c_w-1){1'b1}}};
    end
  end
`else
  logic w_diff_unused;
  assign w_est         = w_diff[c_w-1:0];
  assign w_diff_unused = ^w_diff[c_dw-1:c_w];
`endif

  assign w_capture  = (r_state == c_wait) && (r_cnt == c_fb_lat);
  assign w_decision = f_valid ? feedback_value : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= c_idle;
      r_cnt    <= '0;
      r_sample <= '0;
      r_est    <= '0;
      r_ev     <= 1'b0;
      r_dout   <= '0;
      r_dv     <= 1'b0;
      r_ecnt   <= '0;
      for (int k = 1; k <= c_nt; k++) begin
        r_hist[k] <= '0;
      end
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        c_idle: begin
          if (s_valid) begin
            r_sample <= s_data;
            r_state  <= c_calc;
          end
        end
        c_calc: begin
          r_est   <= w_est;
          r_ev    <= 1'b1;
          r_cnt   <= '0;
          r_state <= c_wait;
        end
        c_wait: begin
          r_ev <= 1'b0;
          if (w_capture) begin
            r_dout  <= w_decision;
            r_dv    <= 1'b1;
            if (!f_valid && (r_ecnt != 16'hFFFF)) begin
              r_ecnt <= r_ecnt + 16'd1;
            end
            r_state <= c_idle;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: r_state <= c_idle;
      endcase

      // A clear coincident with a capture wins; the decision still reaches d_out.
      if (hist_clr) begin
        for (int k = 1; k <= c_nt; k++) begin
          r_hist[k] <= '0;
        end
      end else if (w_capture) begin
        for (int k = c_nt; k >= 2; k--) begin
          r_hist[k] <= r_hist[k-1];
        end
        r_hist[1] <= w_decision;
      end
    end
  end

  assign s_ready     = (r_state == c_idle);
  assign estimation  = r_est;
  assign e_valid     = r_ev;
  assign d_out       = r_dout;
  assign d_valid     = r_dv;
  assign erasure_cnt = r_ecnt;

endmodule
`default_nettype wire

// File: tb/tb_dfe_feedback_canceller.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfe_feedback_canceller
// Description : Directed bench for dfe_feedback_canceller (default parameters).
//               A transaction-level model predicts every output each cycle;
//               directed symbols also carry hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dfe_feedback_canceller;

  localparam int NT  = 1;
  localparam int SR  = 8;
  localparam int W   = 16;
  localparam int FBL = 1;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic signed [W-1:0]   s_data = '0;
  logic                  s_valid = 1'b0;
  logic                  s_ready;
  logic [NT*SR-1:0]      tap_coeff = '0;
  logic                  hist_clr = 1'b0;
  logic signed [W-1:0]   estimation;
  logic                  e_valid;
  logic signed [W-1:0]   feedback_value = '0;
  logic                  f_valid = 1'b0;
  logic signed [W-1:0]   d_out;
  logic                  d_valid;
  logic [15:0]           erasure_cnt;

  int checks = 0;
  int errors = 0;

  dfe_feedback_canceller dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .tap_coeff      (tap_coeff),
    .hist_clr       (hist_clr),
    .estimation     (estimation),
    .e_valid        (e_valid),
    .feedback_value (feedback_value),
    .f_valid        (f_valid),
    .d_out          (d_out),
    .d_valid        (d_valid),
    .erasure_cnt    (erasure_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // floor((isi)/64) then sample - that, reduced to 16 bits.
  function automatic int model_est(input int samp, input longint isi);
    longint q, d;
    q = isi / 64;
    if ((isi % 64 != 0) && (isi < 0)) q = q - 1;
    d = longint'(samp) - q;
`ifdef DFE_SATURATE_EN
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
`else
    d = ((d % 65536) + 65536) % 65536;
    if (d >= 32768) d = d - 65536;
`endif
    return int'(d);
  endfunction

  // ---------------- reference model (edge-count schedule) ----------------
  int  m_hist [NT];
  bit  m_busy = 0;
  int  m_acc  = 0;
  int  m_cyc  = 0;
  int  m_samp = 0;
  bit  m_ev   = 0;
  bit  m_dv   = 0;
  bit  m_rdy  = 1;
  int  m_est  = 0;
  int  m_dout = 0;
  int  m_ecnt = 0;

  initial begin
    foreach (m_hist[i]) m_hist[i] = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_busy = 0; m_ev = 0; m_dv = 0; m_rdy = 1;
        m_est = 0; m_dout = 0; m_ecnt = 0;
        foreach (m_hist[i]) m_hist[i] = 0;
      end else begin
        bit     was_busy;
        int     dec;
        longint isi;
        m_cyc++;
        was_busy = m_busy;
        m_ev = 0;
        m_dv = 0;
        if (was_busy && (m_cyc == m_acc + 1)) begin
          isi = 0;
          for (int i = 0; i < NT; i++)
            isi += longint'(m_hist[i]) * longint'($signed(tap_coeff[(i+1)*SR-1 -: SR]));
          m_est = model_est(m_samp, isi);
          m_ev  = 1;
        end
        if (was_busy && (m_cyc == m_acc + 2 + FBL)) begin
          dec = f_valid ? int'(feedback_value) : 0;
          if (!f_valid && m_ecnt < 65535) m_ecnt++;
          for (int i = NT - 1; i >= 1; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = dec;
          m_dout = dec;
          m_dv   = 1;
          m_busy = 0;
        end
        if (hist_clr) foreach (m_hist[i]) m_hist[i] = 0;
        if (!was_busy && s_valid) begin
          m_busy = 1;
          m_acc  = m_cyc;
          m_samp = int'(s_data);
        end
        m_rdy = !m_busy;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int last_est = 0;
  initial begin
    forever begin
      @(negedge clk);
      check("s_ready",     int'(s_ready),     int'(m_rdy));
      check("e_valid",     int'(e_valid),     int'(m_ev));
      check("d_valid",     int'(d_valid),     int'(m_dv));
      check("erasure_cnt", int'(erasure_cnt), m_ecnt);
      if (m_ev) check("estimation", int'(estimation), m_est);
      if (m_dv) check("d_out",      int'(d_out),      m_dout);
    end
  end

  // ---------------- directed symbol driver ----------------
  task automatic sym(input int samp, input int tap, input int fb, input bit fv,
                     input bit clr, output int est);
    int n;
    est = 0;
    @(negedge clk);
    s_data = W'(samp); tap_coeff = (NT*SR)'(tap); s_valid = 1'b1;
    feedback_value = W'(fb); f_valid = fv;
    n = 0;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    if (!s_ready) begin
      check("accept_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
    n = 1;
    while (!e_valid && n < 20) begin @(negedge clk); n++; end
    check("ev_latency", n, 2);
    est = int'(estimation);
    repeat (FBL) @(negedge clk);
    hist_clr = clr;
    @(negedge clk);
    hist_clr = 1'b0;
    check("dv_pulse", int'(d_valid), 1);
    check("dout_lit", int'(d_out), fv ? fb : 0);
    f_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    // 1. reset
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_s_ready",    int'(s_ready), 1);
    check("rst_e_valid",    int'(e_valid), 0);
    check("rst_estimation", int'(estimation), 0);
    check("rst_d_valid",    int'(d_valid), 0);
    check("rst_d_out",      int'(d_out), 0);
    check("rst_erasure",    int'(erasure_cnt), 0);

    // 2. basic cancellation
    sym(100, 32, 84, 1'b1, 1'b0, e);   check("est_100", e, 100);
    sym(60, 32, -84, 1'b1, 1'b0, e);   check("est_18", e, 18);
    // 3. negative history and floor rounding
    sym(-50, 32, -28, 1'b1, 1'b0, e);  check("est_neg8", e, -8);
    sym(0, 1, 0, 1'b0, 1'b0, e);       check("est_floor1", e, 1);
    // 4. erasure took effect on the previous symbol
    check("erasure_one", int'(erasure_cnt), 1);
    sym(40, 32, -84, 1'b1, 1'b0, e);   check("est_after_erasure", e, 40);
    // 5. overflow handling
    sym(32767, 127, 100, 1'b1, 1'b0, e);
`ifdef DFE_SATURATE_EN
    check("est_sat", e, 32767);
`else
    check("est_wrap", e, -32602);
`endif

    // 6. async reset while e_valid is high
    @(negedge clk);
    s_data = W'(5); tap_coeff = 8'd32; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    check("ev_before_rst", int'(e_valid), 1);
    #2 rstn = 1'b0;
    #1;
    check("async_e_valid", int'(e_valid), 0);
    check("async_s_ready", int'(s_ready), 1);
    check("async_est",     int'(estimation), 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", int'(s_ready), 1);
    sym(100, 32, 84, 1'b1, 1'b0, e);   check("est_after_rst", e, 100);
    sym(70, 32, 20, 1'b1, 1'b1, e);    check("est_28", e, 28);
    sym(55, 32, 0, 1'b1, 1'b0, e);     check("est_after_clr", e, 55);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
